// File: rtl/vred_accum_if.sv
// Handshake bundle between the reduction-tree leaf, the multi-beat accumulator and writeback.
// VRED_ACCUM_MASK_EN adds the per-beat in_mask signal.
interface vred_accum_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int OPSEL_WIDTH = 2,
    parameter int CNT_WIDTH   = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_WIDTH-1:0]  in_data;
    logic [DATA_WIDTH-1:0]  in_seed;
    logic [OPSEL_WIDTH-1:0] in_opSel;
    logic                   in_start;
    logic                   in_last;
`ifdef VRED_ACCUM_MASK_EN
    logic                   in_mask;
`endif
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_WIDTH-1:0]  out_data;
    logic [CNT_WIDTH-1:0]   out_count;
    logic                   out_err;

`ifdef VRED_ACCUM_MASK_EN
    modport master (
        output in_valid, in_data, in_seed, in_opSel, in_start, in_last, in_mask, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_err
    );
    modport slave (
        input  in_valid, in_data, in_seed, in_opSel, in_start, in_last, in_mask, out_ready,
        output in_ready, out_valid, out_data, out_count, out_err
    );
`else
    modport master (
        output in_valid, in_data, in_seed, in_opSel, in_start, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_err
    );
    modport slave (
        input  in_valid, in_data, in_seed, in_opSel, in_start, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_err
    );
`endif
endinterface

// File: rtl/vred_andorxor_accum.sv
// Folds per-beat AND/OR/XOR partial results into one scalar seeded with vs1[0].
// Optional feature: VRED_ACCUM_MASK_EN adds in_mask to skip masked beats.
module vred_andorxor_accum #(
    parameter int DATA_WIDTH  = 32,
    parameter int OPSEL_WIDTH = 2,
    parameter int CNT_WIDTH   = 8
) (
    input logic          clk,
    input logic          rst,
    vred_accum_if.slave  bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [OPSEL_WIDTH-1:0] OP_AND = OPSEL_WIDTH'(1);
    localparam logic [OPSEL_WIDTH-1:0] OP_OR  = OPSEL_WIDTH'(2);
    localparam logic [OPSEL_WIDTH-1:0] OP_XOR = OPSEL_WIDTH'(3);

    logic [1:0]             state;
    logic [DATA_WIDTH-1:0]  acc;
    logic [OPSEL_WIDTH-1:0] op_sel;
    logic [CNT_WIDTH-1:0]   count;
    logic                   err;

    logic                   accept;
    logic                   beat_on;
    logic [OPSEL_WIDTH-1:0] fold_sel;
    logic [DATA_WIDTH-1:0]  fold_a;
    logic [DATA_WIDTH-1:0]  fold_val;
    logic [CNT_WIDTH-1:0]   count_inc;

    function automatic logic [DATA_WIDTH-1:0] apply_op(
        input logic [OPSEL_WIDTH-1:0] sel,
        input logic [DATA_WIDTH-1:0]  a,
        input logic [DATA_WIDTH-1:0]  b
    );
        case (sel)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return '0;
        endcase
    endfunction

`ifdef VRED_ACCUM_MASK_EN
    assign beat_on = bus.in_mask;
`else
    assign beat_on = 1'b1;
`endif

    // Ready is held low for the whole reset window, not just after the first edge.
    assign bus.in_ready = !rst && (state != ST_DONE);
    assign accept       = bus.in_valid && bus.in_ready;

    // A start beat folds against the seed with the incoming op; later beats use the latched op.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        fold_sel = op_sel;
        fold_a   = acc;
        if (state == ST_IDLE) begin
            fold_sel = bus.in_opSel;
            fold_a   = bus.in_seed;
        end
        fold_val  = apply_op(fold_sel, fold_a, bus.in_data);
        count_inc = (count == {CNT_WIDTH{1'b1}}) ? count : count + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the datapath is a handful of flops, not a memory, so it is safe and cheap to reset all of it.
            state  <= ST_IDLE;
            acc    <= '0;
            op_sel <= '0;
            count  <= '0;
            err    <= 1'b0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (bus.in_start) begin
                            op_sel <= bus.in_opSel;
                            acc    <= beat_on ? fold_val : bus.in_seed;
                            count  <= beat_on ? CNT_WIDTH'(1) : '0;
                            state  <= bus.in_last ? ST_DONE : ST_ACC;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_ACC: begin
                    if (accept) begin
                        if (beat_on) begin
                            acc   <= fold_val;
                            count <= count_inc;
                        end
                        // A stray start mid-reduction is flagged but folded in as a plain beat.
                        if (bus.in_start) err   <= 1'b1;
                        if (bus.in_last)  state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.out_valid = (state == ST_DONE);
    assign bus.out_data  = acc;
    assign bus.out_count = count;
    assign bus.out_err   = err;
endmodule

// File: tb/tb_vred_andorxor_accum.sv
// Directed bench for vred_andorxor_accum: vector table plus hand-written corner sequences.
// Build with +define+VRED_ACCUM_MASK_EN to also cover the masked-beat path.
module tb_vred_andorxor_accum;
    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    vred_accum_if #(.DATA_WIDTH(32), .OPSEL_WIDTH(2), .CNT_WIDTH(8)) bus ();

    vred_andorxor_accum #(.DATA_WIDTH(32), .OPSEL_WIDTH(2), .CNT_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0]       seed;
        logic [1:0]        op;
        int                n;
        logic [3:0][31:0]  d;
        logic [31:0]       exp_data;
        logic [7:0]        exp_cnt;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic start, input logic last, input logic [31:0] data,
                              input logic [31:0] seed, input logic [1:0] op);
        bus.in_valid = 1'b1;
        bus.in_start = start;
        bus.in_last  = last;
        bus.in_data  = data;
        bus.in_seed  = seed;
        bus.in_opSel = op;
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0;
        bus.in_start = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Runs one reduction with out_ready high and checks the one-cycle DONE window.
    task automatic run_vec(input vec_t v, input string tag);
        bus.out_ready = 1'b1;
        for (int i = 0; i < v.n; i++) begin
            drive_beat(i == 0, i == v.n - 1, v.d[i], v.seed, v.op);
            tick();
        end
        idle_inputs();
        check({tag, " out_valid"}, {31'd0, bus.out_valid}, 32'd1);
        check({tag, " out_data"},  bus.out_data, v.exp_data);
        check({tag, " out_count"}, {24'd0, bus.out_count}, {24'd0, v.exp_cnt});
        check({tag, " in_ready in DONE"}, {31'd0, bus.in_ready}, 32'd0);
        tick();
        check({tag, " out_valid after accept"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, " out_data held in IDLE"}, bus.out_data, v.exp_data);
    endtask

    initial begin
        vecs[0] = '{seed: 32'h0000_00FF, op: 2'b11, n: 3,
                    d: {32'h0, 32'h0000_FFFF, 32'hFFFF_0000, 32'h0F0F_0F0F},
                    exp_data: 32'hF0F0_F00F, exp_cnt: 8'd3};
        vecs[1] = '{seed: 32'hFFFF_0000, op: 2'b01, n: 1,
                    d: {32'h0, 32'h0, 32'h0, 32'h1234_5678},
                    exp_data: 32'h1234_0000, exp_cnt: 8'd1};
        vecs[2] = '{seed: 32'h0000_0000, op: 2'b10, n: 4,
                    d: {32'h8, 32'h4, 32'h2, 32'h1},
                    exp_data: 32'h0000_000F, exp_cnt: 8'd4};
        vecs[3] = '{seed: 32'h0000_1234, op: 2'b00, n: 2,
                    d: {32'h0, 32'h0, 32'h0000_0001, 32'h0000_0005},
                    exp_data: 32'h0000_0000, exp_cnt: 8'd2};
        vecs[4] = '{seed: 32'hFFFF_FFFF, op: 2'b01, n: 2,
                    d: {32'h0, 32'h0, 32'hFF00_FF00, 32'hF0F0_F0F0},
                    exp_data: 32'hF000_F000, exp_cnt: 8'd2};
        vecs[5] = '{seed: 32'hA5A5_A5A5, op: 2'b11, n: 2,
                    d: {32'h0, 32'h0, 32'h0000_0000, 32'h5A5A_5A5A},
                    exp_data: 32'hFFFF_FFFF, exp_cnt: 8'd2};

        rst = 1'b1;
        idle_inputs();
        bus.in_data   = '0;
        bus.in_seed   = '0;
        bus.in_opSel  = '0;
        bus.out_ready = 1'b1;
`ifdef VRED_ACCUM_MASK_EN
        bus.in_mask   = 1'b1;
`endif
        #12;
        check("reset in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset out_count", {24'd0, bus.out_count}, 32'd0);
        check("reset out_err", {31'd0, bus.out_err}, 32'd0);
        rst = 1'b0;
        tick();
        check("post-reset in_ready", {31'd0, bus.in_ready}, 32'd1);

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));
        check("err clean after table", {31'd0, bus.out_err}, 32'd0);

        // Backpressure: result held, pending start beat waits for the handshake.
        bus.out_ready = 1'b0;
        drive_beat(1'b1, 1'b0, 32'h0000_0001, 32'h0000_0010, 2'b10);
        tick();
        drive_beat(1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 2'b01);
        tick();
        drive_beat(1'b1, 1'b1, 32'h0000_ABCD, 32'hFFFF_FFFF, 2'b01);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp out_valid c%0d", i), {31'd0, bus.out_valid}, 32'd1);
            check($sformatf("bp out_data c%0d", i), bus.out_data, 32'h0000_0111);
            check($sformatf("bp in_ready c%0d", i), {31'd0, bus.in_ready}, 32'd0);
            tick();
        end
        check("bp out_count", {24'd0, bus.out_count}, 32'd2);
        bus.out_ready = 1'b1;
        tick();
        check("bp released out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("bp released out_data held", bus.out_data, 32'h0000_0111);
        tick();
        idle_inputs();
        check("bp next out_valid", {31'd0, bus.out_valid}, 32'd1);
        check("bp next out_data", bus.out_data, 32'h0000_ABCD);
        check("bp next out_count", {24'd0, bus.out_count}, 32'd1);
        tick();

        // Count saturation: 300 contributing beats.
        drive_beat(1'b1, 1'b0, 32'h0, 32'h0, 2'b10);
        tick();
        for (int i = 1; i < 299; i++) begin
            drive_beat(1'b0, 1'b0, 32'h0, 32'h0, 2'b10);
            tick();
        end
        drive_beat(1'b0, 1'b1, 32'h0000_0040, 32'h0, 2'b10);
        tick();
        idle_inputs();
        check("sat out_count", {24'd0, bus.out_count}, 32'd255);
        check("sat out_data", bus.out_data, 32'h0000_0040);
        tick();

        // Start inside ACC: flagged, folded as a normal beat, no restart.
        bus.out_ready = 1'b0;
        drive_beat(1'b1, 1'b0, 32'h1, 32'h0, 2'b10);
        tick();
        drive_beat(1'b1, 1'b0, 32'h2, 32'hFFFF_FFFF, 2'b11);
        tick();
        check("acc-start err", {31'd0, bus.out_err}, 32'd1);
        drive_beat(1'b0, 1'b1, 32'h4, 32'h0, 2'b01);
        tick();
        idle_inputs();
        check("acc-start out_data", bus.out_data, 32'h0000_0007);
        check("acc-start out_count", {24'd0, bus.out_count}, 32'd3);
        check("acc-start out_valid", {31'd0, bus.out_valid}, 32'd1);

        // Asynchronous reset mid-cycle while a result is pending.
        #3;
        rst = 1'b1;
        #1;
        check("async rst out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("async rst out_err", {31'd0, bus.out_err}, 32'd0);
        check("async rst out_count", {24'd0, bus.out_count}, 32'd0);
        check("async rst in_ready", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        tick();

        // Reset in the middle of a reduction drops it with no result.
        drive_beat(1'b1, 1'b0, 32'h3, 32'h0, 2'b10);
        tick();
        idle_inputs();
        #2;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
        tick();
        check("dropped reduction out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("dropped reduction in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Non-start beat in IDLE: discarded, sticky error.
        drive_beat(1'b0, 1'b1, 32'h0000_00AA, 32'h0, 2'b10);
        tick();
        idle_inputs();
        check("idle-nostart out_err", {31'd0, bus.out_err}, 32'd1);
        check("idle-nostart out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("idle-nostart out_count", {24'd0, bus.out_count}, 32'd0);
        tick();
        run_vec(vecs[0], "after-err");
        check("err sticky", {31'd0, bus.out_err}, 32'd1);

`ifdef VRED_ACCUM_MASK_EN
        drive_beat(1'b1, 1'b0, 32'h1, 32'h0, 2'b10);
        tick();
        drive_beat(1'b0, 1'b0, 32'h2, 32'h0, 2'b10);
        bus.in_mask = 1'b0;
        tick();
        bus.in_mask = 1'b1;
        drive_beat(1'b0, 1'b1, 32'h4, 32'h0, 2'b10);
        tick();
        idle_inputs();
        check("mask out_data", bus.out_data, 32'h0000_0005);
        check("mask out_count", {24'd0, bus.out_count}, 32'd2);
        tick();
        drive_beat(1'b1, 1'b1, 32'h0000_00F0, 32'h0000_0003, 2'b10);
        bus.in_mask = 1'b0;
        tick();
        bus.in_mask = 1'b1;
        idle_inputs();
        check("masked start out_data", bus.out_data, 32'h0000_0003);
        check("masked start out_count", {24'd0, bus.out_count}, 32'd0);
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
